// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scan-code decoder (set 2): pops bytes from a receiver FIFO,
// folds E0/F0 prefixes into press/break/repeat events and tracks the held key.
module ps2_kbd_ctrl #(
  parameter bit          REPEAT_EN  = 1'b1,
  parameter logic [15:0] PREFIX_TMO = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_ready,
  input  logic [7:0] ps2_data,
  input  logic       ps2_overflow,
  output logic       ps2_nextdata,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_repeat,
  output logic       held_valid,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] press_cnt,
  output logic       err_ovf,
  output logic       err_kbd
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EMIT,
    SKIP
  } state_t;

  state_t      state;
  logic [7:0]  byte_q;
  logic        ext_pend;
  logic        brk_pend;
  logic [2:0]  skip_cnt;
  logic [15:0] tmo_cnt;

  logic        pend;
  logic        held_match;
  logic        tmo_hit;
  logic [15:0] tmo_next;

  always_comb begin
    pend       = ext_pend | brk_pend | (skip_cnt != 3'd0);
    tmo_next   = tmo_cnt + 16'd1;
    tmo_hit    = (tmo_next >= PREFIX_TMO);
    held_match = held_valid && (held_code == byte_q) && (held_ext == ext_pend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_q       <= '0;
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      skip_cnt     <= '0;
      tmo_cnt      <= '0;
      ps2_nextdata <= 1'b0;
      evt_valid    <= 1'b0;
      evt_code     <= '0;
      evt_ext      <= 1'b0;
      evt_break    <= 1'b0;
      evt_repeat   <= 1'b0;
      held_valid   <= 1'b0;
      held_code    <= '0;
      held_ext     <= 1'b0;
      press_cnt    <= '0;
      err_ovf      <= 1'b0;
      err_kbd      <= 1'b0;
    end else begin
      ps2_nextdata <= 1'b0;
      if (ps2_overflow) err_ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (ps2_ready) begin
            ps2_nextdata <= 1'b1;
            byte_q       <= ps2_data;
            tmo_cnt      <= '0;
            state        <= FETCH;
          end else if (pend) begin
            // A stalled prefix or Pause tail is abandoned after PREFIX_TMO idle cycles
            if (tmo_hit) begin
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
              skip_cnt <= '0;
              tmo_cnt  <= '0;
            end else begin
              tmo_cnt <= tmo_next;
            end
          end else begin
            tmo_cnt <= '0;
          end
        end

        FETCH: state <= DECODE;

        DECODE: begin
          if (skip_cnt != 3'd0) begin
            skip_cnt <= skip_cnt - 3'd1;
            state    <= SKIP;
          end else begin
            case (byte_q)
              8'hE0: begin
                ext_pend <= 1'b1;
                state    <= IDLE;
              end
              8'hF0: begin
                brk_pend <= 1'b1;
                state    <= IDLE;
              end
              8'hE1: begin
                skip_cnt <= 3'd7;
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                state    <= SKIP;
              end
              8'hAA, 8'hFA, 8'hEE: begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                state    <= IDLE;
              end
              8'h00, 8'hFF: begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                err_kbd  <= 1'b1;
                state    <= IDLE;
              end
              default: begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                // Only a repeat with REPEAT_EN=0 is swallowed without an event
                if (brk_pend || !held_match || REPEAT_EN) begin
                  evt_valid  <= 1'b1;
                  evt_code   <= byte_q;
                  evt_ext    <= ext_pend;
                  evt_break  <= brk_pend;
                  evt_repeat <= !brk_pend && held_match;
                  state      <= EMIT;
                end else begin
                  state <= IDLE;
                end
                if (brk_pend) begin
                  if (held_match) held_valid <= 1'b0;
                end else if (!held_match) begin
                  held_valid <= 1'b1;
                  held_code  <= byte_q;
                  held_ext   <= ext_pend;
                  press_cnt  <= press_cnt + 8'd1;
                end
              end
            endcase
          end
        end

        EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        SKIP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Parameter REPEAT_EN, default 1: 1 = typematic repeats are emitted as events with evt_repeat=1; 0 = repeats are dropped silently.
REQ-002 Parameter PREFIX_TMO, default 16'd50000: clk cycles a pending E0/F0/E1 prefix state may wait for its next byte before it is abandoned.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ps2_ready  input  1  receiver FIFO non-empty; ps2_data valid while high.
REQ-006 ps2_data  input  8  scan-code byte at FIFO head.
REQ-007 ps2_overflow  input  1  receiver FIFO overflow flag.
REQ-008 ps2_nextdata  output  1  one-cycle pop strobe to the receiver FIFO.
REQ-009 evt_valid  output  1  key event available; held until accepted.
REQ-010 evt_ready  input  1  consumer accepts the event when evt_valid & evt_ready.
REQ-011 evt_code  output  8  scan code of the event, without prefix.
REQ-012 evt_ext  output  1  event was E0-prefixed.
REQ-013 evt_break  output  1  1 = release, 0 = press.
REQ-014 evt_repeat  output  1  press of the key already held.
REQ-015 held_valid / held_code[7:0] / held_ext  output  1/8/1  currently held key.
REQ-016 press_cnt  output  8  count of new, non-repeat presses.
REQ-017 err_ovf / err_kbd  output  1/1  sticky error flags: FIFO overflow / keyboard error byte (00 or FF).

Function
REQ-018 FSM states: IDLE, FETCH, DECODE, EMIT, SKIP.
REQ-019 IDLE: if ps2_ready=1, assert ps2_nextdata for exactly one cycle, latch ps2_data into byte register in that same cycle, then go to FETCH; otherwise stay in IDLE.
REQ-020 FETCH: one cycle, lets the receiver's ready/pointer update settle; ps2_nextdata=0; next state is DECODE.
REQ-021 DECODE, byte E0: set ext_pend; go to IDLE.
REQ-022 DECODE, byte F0: set brk_pend; go to IDLE.
REQ-023 DECODE, byte E1: load skip counter with 7, clear prefixes, go to SKIP.
REQ-024 SKIP pops and discards bytes through the IDLE/FETCH path without decoding them, decrementing the skip counter per byte; at 0 it returns to normal decode; no event is produced for the Pause sequence.
REQ-025 DECODE, bytes AA, FA, EE: discard and clear prefixes.
REQ-026 DECODE, bytes 00 or FF: discard, clear prefixes, set err_kbd.
REQ-027 DECODE, other byte with brk_pend=1: break event; if held_valid and {held_code, held_ext} matches {byte, ext_pend}, clear held_valid.
REQ-028 DECODE, other byte with brk_pend=0 that matches the held key: repeat; emit with evt_repeat=1 if REPEAT_EN=1, else drop and go to IDLE; press_cnt unchanged.
REQ-029 DECODE, other byte with brk_pend=0 that is not a match: new press; held <= {byte, ext_pend}, held_valid=1, press_cnt += 1 (mod 256, FF wraps to 00).
REQ-030 On any event, evt_* outputs are loaded from the byte and prefix flags, prefixes are cleared, and the FSM goes to EMIT.
REQ-031 EMIT: evt_valid=1 and evt_* stable until evt_ready=1; evt_valid drops in the cycle after the accept edge; no FIFO pop while in EMIT; next state is IDLE.
REQ-032 Decode latency from the pop cycle: evt_valid high 2 cycles later (pop, FETCH, DECODE -> EMIT).
REQ-033 Prefix timeout: counter runs while in IDLE with ext_pend, brk_pend or skip pending; on reaching PREFIX_TMO, clear all prefixes and the skip counter; the counter reloads on every pop.
REQ-034 err_ovf is set on any cycle with ps2_overflow=1 and held until rst; decode continues.
REQ-035 Repeated E0 or F0 bytes are idempotent: the flags stay set.

Reset
REQ-036 On rst=1 at a clk edge, the following SHALL hold next cycle regardless of state (including mid-EMIT or mid-SKIP): state=IDLE, ps2_nextdata=0, evt_valid=0, evt_code=00, evt_ext/evt_break/evt_repeat=0, held_valid=0, held_code=00, held_ext=0, press_cnt=00, err_ovf=0, err_kbd=0, prefixes, skip and timeout counters cleared.

Verification
REQ-037 FIFO 1C, F0, 1C with evt_ready=1 -> events {1C, press}, {1C, break}; press_cnt=1; held_valid=0 at end.
REQ-038 E0 75 E0 75 E0 F0 75, REPEAT_EN=1 -> press ext 75, repeat ext 75, break ext 75; press_cnt=1.
REQ-039 evt_ready=0 for 10 cycles with 1C pending and 2 more bytes queued -> evt_valid held, outputs stable, ps2_nextdata never asserted until accept.
REQ-040 E1 14 77 E1 F0 14 F0 77 then 1C -> no event for the Pause sequence; one event {1C, press}.
REQ-041 F0, then idle for PREFIX_TMO+1 cycles, then 1C -> event is a press, not a break.
REQ-042 Sequence of 256 distinct presses -> press_cnt wraps to 00; rst asserted mid-EMIT -> every output at its reset value next cycle.
